flash_read_bridge: RTL
======================

FLASH_READ_BRIDGE -- requirements
Module: flash_read_bridge

Interface
REQ-001 Parameter ADDR_WIDTH, default 19, word-address width on both sides.
REQ-002 Parameter FLASH_END, default 'h59FF, last word address backed by flash; higher addresses are unmapped.
REQ-003 Parameter MAX_BURST, default 4, maximum words per request; BURST_WIDTH = clog2(MAX_BURST)+1.
REQ-004 Parameter FILL_DATA, default 32'h0000_0000, data returned for unmapped words.
REQ-005 i_clk  in  1  sole clock; all logic on rising edge.
REQ-006 i_reset  in  1  asynchronous, active-high reset.
REQ-007 i_request  in  1  read request, sampled when o_busy low.
REQ-008 i_address  in  ADDR_WIDTH  first word address.
REQ-009 i_burst  in  BURST_WIDTH  word count 1..MAX_BURST.
REQ-010 o_busy  out  1  high while a request is in progress.
REQ-011 o_ack  out  1  one-cycle pulse per returned word.
REQ-012 o_data  out  32  word data, valid when o_ack high.
REQ-013 o_error  out  1  high with o_ack when the word is unmapped.
REQ-014 o_flash_read  out  1  backend read command.
REQ-015 o_flash_address  out  ADDR_WIDTH  backend start address.
REQ-016 o_flash_burstcount  out  BURST_WIDTH  backend word count.
REQ-017 i_flash_waitrequest  in  1  backend stall; command held while high.
REQ-018 i_flash_readdata  in  32  backend data.
REQ-019 i_flash_readdatavalid  in  1  backend data strobe.

Function
REQ-020 Request accepted on a cycle with i_request=1 and o_busy=0; o_busy goes high the next cycle and stays high until the last o_ack cycle, inclusive.
REQ-021 i_burst=0 treated as 1; i_burst>MAX_BURST clamped to MAX_BURST.
REQ-022 Split at accept (ADDR_WIDTH+1-bit arithmetic): N_FLASH = words with address <= FLASH_END, N_DUMMY = remainder; words past 2^ADDR_WIDTH (wrap) count as unmapped.
REQ-023 FSM states: IDLE, CMD, WAIT, DUMMY.
REQ-024 IDLE -> CMD on accept if N_FLASH>0; IDLE -> DUMMY if N_FLASH=0.
REQ-025 CMD: o_flash_read=1, o_flash_address=start, o_flash_burstcount=N_FLASH, all held stable; -> WAIT on first cycle with i_flash_waitrequest=0.
REQ-026 WAIT: each i_flash_readdatavalid produces o_ack=1, o_data=i_flash_readdata, o_error=0 exactly one cycle later (registered); after N_FLASH strobes -> DUMMY if N_DUMMY>0, else IDLE.
REQ-027 DUMMY: one o_ack per cycle, o_data=FILL_DATA, o_error=1, for N_DUMMY cycles, then -> IDLE.
REQ-028 Words returned strictly in ascending address order; first dummy ack no earlier than the cycle after the last flash ack.
REQ-029 First dummy-only ack appears 2 cycles after accept; o_busy falls the cycle after the last ack.
REQ-030 i_flash_readdatavalid in IDLE or CMD ignored; no o_ack generated.
REQ-031 o_data holds the last value when o_ack=0; o_flash_read=0 outside CMD.
REQ-032 i_request while o_busy=1 ignored, not queued.

Reset
REQ-033 While i_reset=1: state IDLE, o_busy=0, o_ack=0, o_error=0, o_data=0, o_flash_read=0, o_flash_address=0, o_flash_burstcount=0, counters 0.
REQ-034 Reset mid-request abandons it; no further acks; backend strobes arriving after reset release ignored per REQ-030.
REQ-035 First request accepted on the first rising edge with i_reset low.

Verification
REQ-036 Single in-range: addr 'h0010, burst 1, waitrequest 2 cycles, valid data 'hCAFE0001 -> one ack with 'hCAFE0001, o_error=0, burstcount 1.
REQ-037 Full burst: addr 'h0100, burst 4, back-to-back valids D0..D3 -> four consecutive acks D0..D3 one cycle delayed, then o_busy low.
REQ-038 Straddle: addr 'h59FE, burst 4 -> flash burstcount 2 at 'h59FE, two data acks, then two acks FILL_DATA with o_error=1.
REQ-039 Unmapped: addr 'h6000, burst 3 -> o_flash_read never high, acks on cycles accept+2..accept+4, all o_error=1.
REQ-040 Wrap: addr 'h7FFFF, burst 2 -> both words unmapped, two error acks.
REQ-041 Reset in WAIT after 1 of 4 valids -> outputs per REQ-033; 3 late valids produce no ack; next request served normally.

Source files
------------

// File: rtl/flash_read_bridge_if.sv
// Purpose : request/response and flash backend bundle for flash_read_bridge.
// Signals : i_request/i_address/i_burst (request in), o_busy/o_ack/o_data/o_error
//           (response out), o_flash_* (backend command out),
//           i_flash_* (backend response in). Names are from the bridge's view.
// Modports: slave = the bridge itself, master = requester plus flash backend.
interface flash_read_bridge_if #(
   parameter int unsigned ADDR_WIDTH = 19,
   parameter int unsigned MAX_BURST  = 4
);
   localparam int unsigned BURST_WIDTH = $clog2(MAX_BURST) + 1;

   logic                   i_request;
   logic [ADDR_WIDTH-1:0]  i_address;
   logic [BURST_WIDTH-1:0] i_burst;
   logic                   o_busy;
   logic                   o_ack;
   logic [31:0]            o_data;
   logic                   o_error;
   logic                   o_flash_read;
   logic [ADDR_WIDTH-1:0]  o_flash_address;
   logic [BURST_WIDTH-1:0] o_flash_burstcount;
   logic                   i_flash_waitrequest;
   logic [31:0]            i_flash_readdata;
   logic                   i_flash_readdatavalid;

   modport slave (
      input  i_request, i_address, i_burst,
      input  i_flash_waitrequest, i_flash_readdata, i_flash_readdatavalid,
      output o_busy, o_ack, o_data, o_error,
      output o_flash_read, o_flash_address, o_flash_burstcount
   );

   modport master (
      output i_request, i_address, i_burst,
      output i_flash_waitrequest, i_flash_readdata, i_flash_readdatavalid,
      input  o_busy, o_ack, o_data, o_error,
      input  o_flash_read, o_flash_address, o_flash_burstcount
   );
endinterface

// File: rtl/flash_read_bridge.sv
// Purpose : bridges word-burst read requests onto a flash backend. Words at or
//           below FLASH_END are read from flash; words above it (including
//           words that wrap past the top of the address space) are returned
//           as FILL_DATA with o_error set, after all flash words.
// Ports   : i_clk, i_reset (async, active high), bus (flash_read_bridge_if.slave).
module flash_read_bridge #(
   parameter int unsigned           ADDR_WIDTH = 19,
   parameter logic [ADDR_WIDTH-1:0] FLASH_END  = ADDR_WIDTH'('h59FF),
   parameter int unsigned           MAX_BURST  = 4,
   parameter logic [31:0]           FILL_DATA  = 32'h0000_0000
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   flash_read_bridge_if.slave    bus
);
   localparam int unsigned BURST_WIDTH = $clog2(MAX_BURST) + 1;
   localparam int unsigned EXT_WIDTH   = ADDR_WIDTH + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CMD,
      ST_WAIT,
      ST_DUMMY
   } state_t;

   state_t                 state;
   logic                   busy_q;
   logic                   ack_q;
   logic [31:0]            data_q;
   logic                   err_q;
   logic                   read_q;
   logic [ADDR_WIDTH-1:0]  faddr_q;
   logic [BURST_WIDTH-1:0] fcount_q;
   logic [BURST_WIDTH-1:0] flash_cnt;
   logic [BURST_WIDTH-1:0] dummy_cnt;

   logic [BURST_WIDTH-1:0] burst_eff;
   logic [BURST_WIDTH-1:0] n_flash;
   logic [BURST_WIDTH-1:0] n_dummy;
   logic [EXT_WIDTH-1:0]   start_ext;
   logic [EXT_WIDTH-1:0]   last_ext;
   logic [EXT_WIDTH-1:0]   end_ext;
   logic [EXT_WIDTH-1:0]   room;

   // Clamp the burst and split it into flash-backed and unmapped words.
   // The extra address bit lets a burst running past the top of the space
   // compare above FLASH_END, so wrapped words land in the unmapped part.
   always_comb begin
      burst_eff = bus.i_burst;
      if (bus.i_burst == '0) begin
         burst_eff = BURST_WIDTH'(1);
      end else if (bus.i_burst > BURST_WIDTH'(MAX_BURST)) begin
         burst_eff = BURST_WIDTH'(MAX_BURST);
      end
      start_ext = {1'b0, bus.i_address};
      end_ext   = {1'b0, FLASH_END};
      last_ext  = start_ext + EXT_WIDTH'(burst_eff) - EXT_WIDTH'(1);
      room      = end_ext - start_ext + EXT_WIDTH'(1);
      if (start_ext > end_ext) begin
         n_flash = '0;
      end else if (last_ext <= end_ext) begin
         n_flash = burst_eff;
      end else begin
         // Only reached when room < burst_eff, so truncation is lossless.
         n_flash = BURST_WIDTH'(room);
      end
      n_dummy = burst_eff - n_flash;
   end

   // Request sequencer: accept, command flash, collect data, emit fill words.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state     <= ST_IDLE;
         busy_q    <= 1'b0;
         ack_q     <= 1'b0;
         data_q    <= '0;
         err_q     <= 1'b0;
         read_q    <= 1'b0;
         faddr_q   <= '0;
         fcount_q  <= '0;
         flash_cnt <= '0;
         dummy_cnt <= '0;
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               // busy stays up through the last ack cycle, so drop it here
               // before a new request can be sampled.
               if (busy_q) begin
                  busy_q <= 1'b0;
               end else if (bus.i_request) begin
                  busy_q    <= 1'b1;
                  faddr_q   <= bus.i_address;
                  fcount_q  <= n_flash;
                  flash_cnt <= n_flash;
                  dummy_cnt <= n_dummy;
                  if (n_flash != '0) begin
                     state  <= ST_CMD;
                     read_q <= 1'b1;
                  end else begin
                     state <= ST_DUMMY;
                  end
               end
            end
            ST_CMD: begin
               if (!bus.i_flash_waitrequest) begin
                  read_q <= 1'b0;
                  state  <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (bus.i_flash_readdatavalid) begin
                  ack_q     <= 1'b1;
                  data_q    <= bus.i_flash_readdata;
                  flash_cnt <= flash_cnt - BURST_WIDTH'(1);
                  if (flash_cnt == BURST_WIDTH'(1)) begin
                     state <= (dummy_cnt != '0) ? ST_DUMMY : ST_IDLE;
                  end
               end
            end
            ST_DUMMY: begin
               ack_q     <= 1'b1;
               data_q    <= FILL_DATA;
               err_q     <= 1'b1;
               dummy_cnt <= dummy_cnt - BURST_WIDTH'(1);
               if (dummy_cnt == BURST_WIDTH'(1)) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.o_busy             = busy_q;
   assign bus.o_ack              = ack_q;
   assign bus.o_data             = data_q;
   assign bus.o_error            = err_q;
   assign bus.o_flash_read       = read_q;
   assign bus.o_flash_address    = faddr_q;
   assign bus.o_flash_burstcount = fcount_q;
endmodule
